// File: rtl/adder_rv_arbiter.sv
// Round-robin arbiter sharing one ready/valid adder among N requester ports.
// Results return strictly in issue order; an in-order tag FIFO steers each sum to its issuer.
module adder_rv_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req_valid,
    output logic [N-1:0]               req_ready,
    input  logic [N*W-1:0]             req_a,
    input  logic [N*W-1:0]             req_b,
    output logic [N-1:0]               rsp_valid,
    input  logic [N-1:0]               rsp_ready,
    output logic [W-1:0]               rsp_sum,
    output logic                       add_in_valid,
    input  logic                       add_in_ready,
    output logic [W-1:0]               add_in_a,
    output logic [W-1:0]               add_in_b,
    input  logic                       add_out_valid,
    output logic                       add_out_ready,
    input  logic [W-1:0]               add_out_sum,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       idle
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  op_a [N];
    logic [W-1:0]  op_b [N];

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] cand;
    logic          grant_found;
    logic [IW-1:0] grant_idx;
    logic          can_load;
    logic          accept;

    logic          slot_valid_q, slot_valid_d;
    logic [W-1:0]  slot_a_q, slot_a_d;
    logic [W-1:0]  slot_b_q, slot_b_d;
    logic [IW-1:0] slot_tag_q, slot_tag_d;

    logic [IW-1:0] tag_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [IW-1:0] head_tag;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            op_a[i] = req_a[i*W +: W];
            op_b[i] = req_b[i*W +: W];
        end
    end

    // Search starts at the round-robin pointer and wraps once around all ports.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(rr_ptr_q) + k) % N);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    // A pop in the same cycle deliberately does not free a FIFO entry for the load.
    assign can_load   = (!slot_valid_q || add_in_ready) && !fifo_full;
    assign accept     = !rst && can_load && grant_found;
    assign push       = accept;
    assign head_tag   = tag_mem_q[rd_ptr_q];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // The slot only changes when it is empty or its contents are being taken.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_a_d     = slot_a_q;
        slot_b_d     = slot_b_q;
        slot_tag_d   = slot_tag_q;
        if (accept) begin
            slot_valid_d = 1'b1;
            slot_a_d     = op_a[grant_idx];
            slot_b_d     = op_b[grant_idx];
            slot_tag_d   = grant_idx;
        end else if (add_in_ready) begin
            slot_valid_d = 1'b0;
        end
    end

    assign add_in_valid = slot_valid_q;
    assign add_in_a     = slot_a_q;
    assign add_in_b     = slot_b_q;

    assign add_out_ready = !fifo_empty && rsp_ready[head_tag];
    assign pop           = add_out_valid && add_out_ready;
    assign rsp_sum       = add_out_sum;

    always_comb begin
        rsp_valid = '0;
        if (!rst && add_out_valid && !fifo_empty) begin
            rsp_valid[head_tag] = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign outstanding = count_q;
    assign idle        = !slot_valid_q && fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            slot_valid_q <= 1'b0;
            slot_a_q     <= '0;
            slot_b_q     <= '0;
            slot_tag_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            slot_valid_q <= slot_valid_d;
            slot_a_q     <= slot_a_d;
            slot_b_q     <= slot_b_d;
            slot_tag_q   <= slot_tag_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    // A result with nothing outstanding means the adder broke protocol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(add_out_valid && fifo_empty));
            assert (count_q <= CW'(DEPTH));
            assert (!slot_valid_q || tag_mem_q[wr_ptr_q - PW'(1)] == slot_tag_q);
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (add_in_valid && !add_in_ready) |=>
        (add_in_valid && $stable(add_in_a) && $stable(add_in_b)));

endmodule
